hgate_mmio_master: RTL and testbench

// - Initiator side of the H-Gate MMIO register bank: turns one high-level request (command + optional 256-bit payload) into the MMIO write/poll/read sequence.
// - Sits between the boot/host controller and the H-Gate core; sole driver of mmio_we/addr/wdata; consumes mmio_rdata/busy.
// - Returns result words (PCR, DATA_OUT or COUNTER), the final STATUS read and an error flag.

---
 rtl/hgate_mmio_master.sv | 189 ++++++++++++++++++
 tb/tb_hgate_mmio_master.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hgate_mmio_master.sv
// H-Gate MMIO initiator: one request -> write/poll/read sequence.
// Optional busy-wait timeout enabled by HGATE_MST_TIMEOUT_EN.
module hgate_mmio_master #(
  parameter int TMO_W      = 16,
  parameter int TMO_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [7:0]   req_cmd,
  input  logic         req_load,
  input  logic [255:0] req_data,
  input  logic [1:0]   req_rd_sel,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [255:0] resp_data,
  output logic [2:0]   resp_status,
  output logic         resp_err,
  output logic         mmio_we,
  output logic [7:0]   mmio_addr,
  output logic [31:0]  mmio_wdata,
  input  logic [31:0]  mmio_rdata,
  input  logic         busy
);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_CMD,
    WAIT_BUSY,
    RD,
    STAT,
    RESP
  } state_t;

  localparam logic [7:0] A_CMD  = 8'h00;
  localparam logic [7:0] A_STAT = 8'h04;
  localparam logic [7:0] A_DIN  = 8'h30;

  state_t       state;
  logic [2:0]   idx;
  logic [2:0]   idx_nx;
  logic [7:0]   cmd_q;
  logic [255:0] data_q;
  logic [1:0]   sel_q;
  logic [7:0]   rd_base;
  logic [2:0]   rd_last;

`ifdef HGATE_MST_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  logic [TMO_W-1:0] tmo;
  logic             err_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign idx_nx = idx + 3'd1;

  // Read window base address and last word index for the selected bank
  always_comb begin
    rd_base = A_STAT;
    rd_last = 3'd7;
    unique case (sel_q)
      2'd1: rd_base = 8'h10;
      2'd2: rd_base = 8'h50;
      2'd3: begin
        rd_base = 8'h08;
        rd_last = 3'd1;
      end
      default: ;
    endcase
  end

  // Sequencer: state, captured request and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_status <= '0;
      mmio_we     <= 1'b0;
      mmio_addr   <= A_STAT;
      mmio_wdata  <= '0;
`ifdef HGATE_MST_TIMEOUT_EN
      tmo         <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          mmio_we   <= 1'b0;
          mmio_addr <= A_STAT;
          if (req_valid && req_ready) begin
            cmd_q     <= req_cmd;
            data_q    <= req_data;
            sel_q     <= req_rd_sel;
            resp_data <= '0;
            req_ready <= 1'b0;
            idx       <= '0;
            mmio_we   <= 1'b1;
`ifdef HGATE_MST_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            if (req_load) begin
              state      <= WR_DATA;
              mmio_addr  <= A_DIN;
              mmio_wdata <= req_data[31:0];
            end else begin
              state      <= WR_CMD;
              mmio_addr  <= A_CMD;
              mmio_wdata <= {24'd0, req_cmd};
            end
          end
        end
        WR_DATA: begin
          if (idx == 3'd7) begin
            state      <= WR_CMD;
            mmio_addr  <= A_CMD;
            mmio_wdata <= {24'd0, cmd_q};
          end else begin
            idx        <= idx_nx;
            mmio_addr  <= mmio_addr + 8'd4;
            mmio_wdata <= data_q[{idx_nx, 5'd0} +: 32];
          end
        end
        WR_CMD: begin
          state      <= WAIT_BUSY;
          mmio_we    <= 1'b0;
          mmio_addr  <= A_STAT;
          mmio_wdata <= '0;
`ifdef HGATE_MST_TIMEOUT_EN
          tmo        <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (!busy) begin
            idx <= '0;
            if (sel_q == 2'd0) begin
              state <= STAT;
            end else begin
              state     <= RD;
              mmio_addr <= rd_base;
            end
          end
`ifdef HGATE_MST_TIMEOUT_EN
          else if (tmo == TMO_LAST) begin
            err_q <= 1'b1;
            state <= STAT;
          end else begin
            tmo <= tmo + 1'b1;
          end
`endif
        end
        RD: begin
          resp_data[{idx, 5'd0} +: 32] <= mmio_rdata;
          if (idx == rd_last) begin
            state     <= STAT;
            mmio_addr <= A_STAT;
          end else begin
            idx       <= idx_nx;
            mmio_addr <= mmio_addr + 8'd4;
          end
        end
        STAT: begin
          resp_status <= mmio_rdata[2:0];
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hgate_mmio_master.sv
// Directed bench for hgate_mmio_master with a small H-Gate target model.
// Timeout scenario runs when HGATE_MST_TIMEOUT_EN is defined.
module tb_hgate_mmio_master;

`ifdef HGATE_MST_TIMEOUT_EN
  localparam int TMO    = 16;
  localparam int BUSY_N = 10;
`else
  localparam int TMO    = 4096;
  localparam int BUSY_N = 50;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [7:0]   req_cmd = '0;
  logic         req_load = 1'b0;
  logic [255:0] req_data = '0;
  logic [1:0]   req_rd_sel = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [255:0] resp_data;
  logic [2:0]   resp_status;
  logic         resp_err;
  logic         mmio_we;
  logic [7:0]   mmio_addr;
  logic [31:0]  mmio_wdata;
  logic [31:0]  mmio_rdata;
  logic         busy = 1'b0;

  hgate_mmio_master #(.TMO_W(16), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_load(req_load),
    .req_data(req_data), .req_rd_sel(req_rd_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_status(resp_status),
    .resp_err(resp_err),
    .mmio_we(mmio_we), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // target model
  logic [31:0] din [8];
  logic [31:0] pcr [8];
  logic [31:0] dout [8];
  logic [63:0] counter = '0;
  int          bcnt = 0;
  int          busy_len = 0;
  logic        busy_stuck = 1'b0;
  logic [2:0]  status_val = '0;
  logic [7:0]  off_din, off_pcr, off_dout;

  assign off_din  = mmio_addr - 8'h30;
  assign off_pcr  = mmio_addr - 8'h10;
  assign off_dout = mmio_addr - 8'h50;

  always_comb begin
    mmio_rdata = 32'hDEAD_BEEF;
    if (mmio_addr == 8'h04) mmio_rdata = {29'd0, status_val};
    else if (mmio_addr == 8'h08) mmio_rdata = counter[31:0];
    else if (mmio_addr == 8'h0C) mmio_rdata = counter[63:32];
    else if (mmio_addr >= 8'h10 && mmio_addr <= 8'h2C)
      mmio_rdata = pcr[off_pcr[4:2]];
    else if (mmio_addr >= 8'h50 && mmio_addr <= 8'h6C)
      mmio_rdata = dout[off_dout[4:2]];
  end

  always @(posedge clk) begin
    if (mmio_we && mmio_addr >= 8'h30 && mmio_addr <= 8'h4C)
      din[off_din[4:2]] <= mmio_wdata;
    if (mmio_we && mmio_addr == 8'h00) begin
      if (mmio_wdata[7:0] == 8'h02)
        for (int k = 0; k < 8; k++) pcr[k] <= pcr[k] ^ din[k];
      if (mmio_wdata[7:0] == 8'h03)
        for (int k = 0; k < 8; k++) dout[k] <= din[k] ^ 32'hA5A5_0000;
      if (mmio_wdata[7:0] == 8'h05) counter <= counter + 64'd1;
      busy <= busy_stuck || (busy_len != 0);
      bcnt <= (busy_len == 0) ? 0 : busy_len - 1;
    end else if (busy_stuck) begin
      busy <= 1'b1;
    end else if (busy) begin
      if (bcnt == 0) busy <= 1'b0;
      else bcnt <= bcnt - 1;
    end
  end

  // bus monitor
  logic [7:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int rd_cnt = 0;
  int wait_cyc = 0;
  int busy_cyc = 0;
  bit cmd_seen = 0;
  bit rd_started = 0;

  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (mmio_we) begin
      wr_addr.push_back(mmio_addr);
      wr_data.push_back(mmio_wdata);
      if (mmio_addr == 8'h00) cmd_seen = 1;
    end else if (mmio_addr != 8'h04) begin
      rd_cnt++;
      if (cmd_seen) rd_started = 1;
    end else if (cmd_seen && !rd_started) begin
      wait_cyc++;
    end
  end

  int passed = 0;
  int total = 0;
  int lat;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic ld, input logic [255:0] d,
                       input logic [7:0] c, input logic [1:0] s,
                       input int limit);
    int n;
    @(negedge clk);
    req_load = ld;
    req_data = d;
    req_cmd = c;
    req_rd_sel = s;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd = 8'hFF;
    req_data = '1;
    req_load = 1'b1;
    req_rd_sel = 2'd1;
    wr_addr.delete();
    wr_data.delete();
    rd_cnt = 0;
    wait_cyc = 0;
    busy_cyc = 0;
    cmd_seen = 0;
    rd_started = 0;
    lat = 0;
    while (!resp_valid && lat < limit) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_valid_wait", resp_valid, 1'b1);
  endtask

  task automatic accept();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_valid_low", resp_valid, 1'b0);
    chk("accept_ready_high", req_ready, 1'b1);
    resp_ready = 1'b0;
  endtask

  logic [255:0] d1, d2, exp;
  int n;

  initial begin
    for (int k = 0; k < 8; k++) begin
      din[k] = '0;
      pcr[k] = '0;
      dout[k] = '0;
    end
    for (int k = 0; k < 8; k++) begin
      d1[32*k +: 32] = 32'h1000_0000 + k;
      d2[32*k +: 32] = 32'h2000_0000 + 32'h11 * k;
    end

    // reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, '0);
    chk("rst_resp_status", resp_status, 3'd0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_we", mmio_we, 1'b0);
    chk("rst_addr", mmio_addr, 8'h04);
    chk("rst_wdata", mmio_wdata, 32'd0);
    @(posedge clk);
    #1 chk("rst_hold_ready", req_ready, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", req_ready, 1'b1);

    // load + PCR read
    status_val = 3'b101;
    issue(1'b1, d1, 8'h02, 2'd1, 100);
    chk("t1_latency", lat, 20);
    chk("t1_nwr", wr_addr.size(), 9);
    for (int k = 0; k < 8; k++) begin
      chk("t1_wr_addr", wr_addr[k], 8'h30 + 8'(4 * k));
      chk("t1_wr_data", wr_data[k], 32'h1000_0000 + k);
    end
    chk("t1_cmd_addr", wr_addr[8], 8'h00);
    chk("t1_cmd_data", wr_data[8], 32'h02);
    chk("t1_resp_data", resp_data, d1);
    chk("t1_status", resp_status, 3'b101);
    chk("t1_err", resp_err, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_data", resp_data, d1);
      chk("hold_status", resp_status, 3'b101);
      chk("hold_req_ready", req_ready, 1'b0);
      chk("hold_we", mmio_we, 1'b0);
      chk("hold_addr", mmio_addr, 8'h04);
    end
    accept();

    // counter increments, then COUNTER read
    status_val = 3'b010;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, '0, 8'h05, 2'd0, 100);
      chk("t2_latency", lat, 4);
      chk("t2_nwr", wr_addr.size(), 1);
      chk("t2_wr_addr", wr_addr[0], 8'h00);
      chk("t2_wr_data", wr_data[0], 32'h05);
      chk("t2_resp_data", resp_data, '0);
      chk("t2_status", resp_status, 3'b010);
      accept();
    end
    issue(1'b0, '0, 8'h00, 2'd3, 100);
    chk("t2_cnt_data", resp_data, 256'd3);
    chk("t2_cnt_nwr", wr_addr.size(), 1);
    chk("t2_cnt_rd", rd_cnt, 2);
    accept();

    // busy held, DATA_OUT read
    status_val = 3'b011;
    busy_len = BUSY_N;
    issue(1'b0, '0, 8'h03, 2'd2, 500);
    busy_len = 0;
    chk("t3_busy_cyc", busy_cyc, BUSY_N);
    chk("t3_wait_cyc", wait_cyc, BUSY_N + 1);
    for (int k = 0; k < 8; k++) exp[32*k +: 32] = 32'hB5A5_0000 + k;
    chk("t3_resp_data", resp_data, exp);
    chk("t3_err", resp_err, 1'b0);
    chk("t3_rd", rd_cnt, 8);
    accept();

`ifdef HGATE_MST_TIMEOUT_EN
    // busy stuck -> timeout
    status_val = 3'b110;
    busy_stuck = 1'b1;
    issue(1'b0, '0, 8'h03, 2'd2, 200);
    chk("tmo_latency", lat, 19);
    chk("tmo_err", resp_err, 1'b1);
    chk("tmo_data", resp_data, '0);
    chk("tmo_rd", rd_cnt, 0);
    chk("tmo_status", resp_status, 3'b110);
    busy_stuck = 1'b0;
    accept();
    repeat (3) @(negedge clk);
`endif

    // reset mid write burst
    @(negedge clk);
    req_load = 1'b1;
    req_data = d2;
    req_cmd = 8'h03;
    req_rd_sel = 2'd2;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!(mmio_we && mmio_addr == 8'h3C) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_word3", mmio_addr, 8'h3C);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", mmio_we, 1'b0);
    chk("rst_mid_addr", mmio_addr, 8'h04);
    chk("rst_mid_valid", resp_valid, 1'b0);
    chk("rst_mid_ready", req_ready, 1'b0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    status_val = 3'b001;
    issue(1'b1, d2, 8'h03, 2'd2, 100);
    chk("t4_latency", lat, 20);
    chk("t4_nwr", wr_addr.size(), 9);
    chk("t4_first_addr", wr_addr[0], 8'h30);
    chk("t4_first_data", wr_data[0], 32'h2000_0000);
    for (int k = 0; k < 8; k++)
      exp[32*k +: 32] = 32'h85A5_0000 + 32'h11 * k;
    chk("t4_resp_data", resp_data, exp);
    chk("t4_status", resp_status, 3'b001);
    accept();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
